// File: rtl/sigma_shift_scheduler_pkg.sv
// Shared definitions for the sigma shift scheduler: function codes, FSM
// state constants, per-function op tables and a bit-reversal helper.
package sigma_shift_scheduler_pkg;

  localparam logic [1:0] funcBigSigma0   = 2'b00;
  localparam logic [1:0] funcBigSigma1   = 2'b01;
  localparam logic [1:0] funcSmallSigma0 = 2'b10;
  localparam logic [1:0] funcSmallSigma1 = 2'b11;

  localparam logic [1:0] stateIdle = 2'd0;
  localparam logic [1:0] stateRun  = 2'd1;
  localparam logic [1:0] stateDone = 2'd2;

  // Op table entry {isRot, amt} for a function and op-table step (0..2).
  function automatic logic [5:0] opEntry(input logic [1:0] func, input logic [1:0] step);
    logic [5:0] entry;
    entry = 6'd0;
    case (func)
      funcBigSigma0: begin
        case (step)
          2'd0:    entry = {1'b1, 5'd2};
          2'd1:    entry = {1'b1, 5'd13};
          default: entry = {1'b1, 5'd22};
        endcase
      end
      funcBigSigma1: begin
        case (step)
          2'd0:    entry = {1'b1, 5'd6};
          2'd1:    entry = {1'b1, 5'd11};
          default: entry = {1'b1, 5'd25};
        endcase
      end
      funcSmallSigma0: begin
        case (step)
          2'd0:    entry = {1'b1, 5'd7};
          2'd1:    entry = {1'b1, 5'd18};
          default: entry = {1'b0, 5'd3};
        endcase
      end
      default: begin
        case (step)
          2'd0:    entry = {1'b1, 5'd17};
          2'd1:    entry = {1'b1, 5'd19};
          default: entry = {1'b0, 5'd10};
        endcase
      end
    endcase
    return entry;
  endfunction

  // Number of shifter micro-ops: three rotates cost 6, two rotates plus a shift cost 5.
  function automatic logic [2:0] opCount(input logic [1:0] func);
    return func[1] ? 3'd5 : 3'd6;
  endfunction

  function automatic logic [31:0] bitReverse(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = x[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sigma_shift_scheduler_rotr_step.sv
// One shifter micro-op: either a plain logical right shift, or the left half
// of a rotate built from the same right shifter by reversing in and out.
module rotr_step
  import sigma_shift_scheduler_pkg::*;
(
  input  logic [31:0] x,
  input  logic [4:0]  amt,
  input  logic        leftHalf,
  output logic [31:0] result
);

  logic [31:0] shIn;
  logic [31:0] shOut;

  assign shIn   = leftHalf ? bitReverse(x) : x;
  // The single right barrel shifter shared by every micro-op.
  assign shOut  = shIn >> amt;
  assign result = leftHalf ? bitReverse(shOut) : shOut;

endmodule

// File: rtl/sigma_shift_scheduler.sv
// Shares one right shifter between the message-schedule port (0) and the
// compression-round port (1) to evaluate SHA-256 Sigma0/Sigma1/sigma0/sigma1.
//
// state | meaning
// IDLE  | waiting for a request; req_ready carries the arbitration grant
// RUN   | one shifter micro-op per cycle, XOR-accumulated into acc
// DONE  | result presented to the owning port until it takes it
module sigma_shift_scheduler
  import sigma_shift_scheduler_pkg::*;
#(
  parameter logic        RR_INIT   = 1'b0,
  parameter int unsigned ENABLE_RR = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_func0,
  input  logic [31:0] req_data0,
  input  logic [1:0]  req_func1,
  input  logic [31:0] req_data1,
  output logic [31:0] res_data,
  output logic [1:0]  res_valid,
  input  logic [1:0]  res_ready,
  output logic        busy
);

  logic [1:0]  state;
  logic [2:0]  opCnt;
  logic [31:0] acc;
  logic [31:0] xReg;
  logic [1:0]  funcReg;
  logic        idReg;
  logic        rrPtr;

  logic        grantId;
  logic [1:0]  grant;
  logic [5:0]  entry;
  logic        leftHalf;
  logic [4:0]  stepAmt;
  logic [31:0] stepResult;
  logic        lastOp;

  // Arbitration: a lone valid wins; a tie goes to the pointer port (or port 0 when fixed).
  always_comb begin
    grantId = 1'b0;
    grant   = 2'b00;
    if (req_valid == 2'b11) begin
      grantId = (ENABLE_RR != 0) ? rrPtr : 1'b0;
    end else if (req_valid[1]) begin
      grantId = 1'b1;
    end
    if (req_valid != 2'b00) begin
      grant = grantId ? 2'b10 : 2'b01;
    end
  end

  assign req_ready = (state == stateIdle) ? grant : 2'b00;

  // Decode the current micro-op: even op is the right half of a table entry, odd op the rotate's left half.
  always_comb begin
    entry    = opEntry(funcReg, opCnt[2:1]);
    leftHalf = entry[5] & opCnt[0];
    // 32-n in five bits is just the two's complement of n; n is never 0 here.
    stepAmt  = leftHalf ? (5'd0 - entry[4:0]) : entry[4:0];
    lastOp   = (opCnt == (opCount(funcReg) - 3'd1));
  end

  rotr_step uRotrStep (
    .x        (xReg),
    .amt      (stepAmt),
    .leftHalf (leftHalf),
    .result   (stepResult)
  );

  // Sequencer: accept, run the micro-ops into acc, hold the result until taken.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= stateIdle;
      opCnt   <= 3'd0;
      acc     <= 32'd0;
      xReg    <= 32'd0;
      funcReg <= 2'b00;
      idReg   <= 1'b0;
      rrPtr   <= RR_INIT;
    end else begin
      case (state)
        stateIdle: begin
          if ((req_valid & req_ready) != 2'b00) begin
            xReg    <= grantId ? req_data1 : req_data0;
            funcReg <= grantId ? req_func1 : req_func0;
            idReg   <= grantId;
            acc     <= 32'd0;
            opCnt   <= 3'd0;
            state   <= stateRun;
            if (ENABLE_RR != 0) begin
              rrPtr <= ~grantId;
            end
          end
        end
        stateRun: begin
          acc   <= acc ^ stepResult;
          opCnt <= opCnt + 3'd1;
          if (lastOp) begin
            state <= stateDone;
          end
        end
        stateDone: begin
          if (res_ready[idReg]) begin
            state <= stateIdle;
          end
        end
        default: state <= stateIdle;
      endcase
    end
  end

  assign res_valid = (state == stateDone) ? (idReg ? 2'b10 : 2'b01) : 2'b00;
  assign res_data  = (state == stateDone) ? acc : 32'd0;
  assign busy      = (state != stateIdle);

endmodule
